// File: rtl/mcmem_wait_if.sv
// ============================================================================
// Module   : mcmem_wait_if
// Brief    : Request/ready memory bus between the multi-cycle CPU and mcmem_wait
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mcmem_wait_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] datain;
    logic [31:0] dataout;
    logic        rdy;
    logic        busy;
    logic        err;

    modport master (
        output req, we, be, addr, datain,
        input  dataout, rdy, busy, err
    );

    modport slave (
        input  req, we, be, addr, datain,
        output dataout, rdy, busy, err
    );
endinterface

`default_nettype wire

// File: rtl/mcmem_wait.sv
// ============================================================================
// Module   : mcmem_wait
// Brief    : Single-port word memory with programmable wait states, a one-cycle
//            rdy pulse and out-of-range detection. Define MCMEM_BYTE_EN to
//            honour per-lane byte enables on writes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcmem_wait #(
    parameter int DEPTH_LOG2  = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  wire logic   clk,
    input  wire logic   rst,
    mcmem_wait_if.slave bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       dataout_q, dataout_d;
    logic              err_q, err_d;

    logic [31:0]       mem [DEPTH] = '{default: 32'h0};

    logic              w_access;
    logic              w_acc_we;
    logic [3:0]        w_acc_be;
    logic [31:0]       w_acc_addr;
    logic [31:0]       w_acc_data;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic              w_oob;
    logic [3:0]        w_lane_en;

    // With zero wait states the access happens at the accept edge, so it must
    // see the bus values directly rather than the not-yet-latched copies.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        data_d     = data_q;
        dataout_d  = dataout_q;
        err_d      = err_q;
        w_access   = 1'b0;
        w_acc_we   = we_q;
        w_acc_be   = be_q;
        w_acc_addr = addr_q;
        w_acc_data = data_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    we_d   = bus.we;
                    be_d   = bus.be;
                    addr_d = bus.addr;
                    data_d = bus.datain;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_DONE;
                        w_access   = 1'b1;
                        w_acc_we   = bus.we;
                        w_acc_be   = bus.be;
                        w_acc_addr = bus.addr;
                        w_acc_data = bus.datain;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = S_DONE;
                    w_access = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        w_idx = w_acc_addr[DEPTH_LOG2+1:2];
        w_oob = |w_acc_addr[31:DEPTH_LOG2+2];

        if (w_access) begin
            err_d = w_oob;
            if (w_oob) begin
                dataout_d = 32'h0;
            end else if (!w_acc_we) begin
                dataout_d = mem[w_idx];
            end
        end
    end

`ifdef MCMEM_BYTE_EN
    assign w_lane_en = w_acc_be;
`else
    assign w_lane_en = 4'hF;
`endif

    logic w_unused;
    assign w_unused = ^{w_acc_addr[1:0], w_acc_be};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            be_q      <= 4'h0;
            addr_q    <= 32'h0;
            data_q    <= 32'h0;
            dataout_q <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            be_q      <= be_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            dataout_q <= dataout_d;
            err_q     <= err_d;
        end
    end

    // The array is deliberately outside the reset domain; rst only blocks a write.
    always_ff @(posedge clk) begin
        if (!rst && w_access && w_acc_we && !w_oob) begin
            for (int i = 0; i < 4; i++) begin
                if (w_lane_en[i]) begin
                    mem[w_idx][8*i +: 8] <= w_acc_data[8*i +: 8];
                end
            end
        end
    end

    assign bus.dataout = dataout_q;
    assign bus.rdy     = (state_q == S_DONE);
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.err     = err_q & (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_mcmem_wait.sv
// ============================================================================
// Module   : tb_mcmem_wait
// Brief    : Scoreboard bench for mcmem_wait at WAIT_CYCLES = 0, 2 and 4
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mcmem_wait;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst4 = 1'b1;
    int   cyc  = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mcmem_wait_if bus0 ();
    mcmem_wait_if bus2 ();
    mcmem_wait_if bus4 ();

    mcmem_wait #(.DEPTH_LOG2(6), .WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst),  .bus(bus0));
    mcmem_wait #(.DEPTH_LOG2(6), .WAIT_CYCLES(2)) u_dut2 (.clk(clk), .rst(rst),  .bus(bus2));
    mcmem_wait #(.DEPTH_LOG2(6), .WAIT_CYCLES(4)) u_dut4 (.clk(clk), .rst(rst4), .bus(bus4));

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          cyc;
        int          tag;
    } exp_t;

    exp_t q0[$];
    exp_t q2[$];
    exp_t q4[$];

    task automatic chk(input int tag, input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL tag%0d %s: got %h, want %h", tag, what, act, exp);
        end
    endtask

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            2:       return q2.size();
            default: return q4.size();
        endcase
    endfunction

    function automatic logic busy_of(input int k);
        case (k)
            0:       return bus0.busy;
            2:       return bus2.busy;
            default: return bus4.busy;
        endcase
    endfunction

    task automatic push(input int k, input logic [31:0] d, input logic e, input int c, input int tag);
        exp_t x;
        x.d = d; x.e = e; x.cyc = c; x.tag = tag;
        case (k)
            0:       q0.push_back(x);
            2:       q2.push_back(x);
            default: q4.push_back(x);
        endcase
    endtask

    task automatic mon(input int k, input logic r, input logic [31:0] d, input logic e);
        exp_t x;
        if (r !== 1'b1) return;
        if (qsize(k) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rdy W%0d at cycle %0d: got rdy=1, want rdy=0", k, cyc);
            return;
        end
        case (k)
            0:       x = q0.pop_front();
            2:       x = q2.pop_front();
            default: x = q4.pop_front();
        endcase
        chk(x.tag, "dataout", d, x.d);
        chk(x.tag, "err", {31'b0, e}, {31'b0, x.e});
        chk(x.tag, "rdy_cycle", cyc, x.cyc);
    endtask

    always @(negedge clk) begin
        mon(0, bus0.rdy, bus0.dataout, bus0.err);
        mon(2, bus2.rdy, bus2.dataout, bus2.err);
        mon(4, bus4.rdy, bus4.dataout, bus4.err);
    end

    task automatic drive(input int k, input logic rq, input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] dn);
        case (k)
            0: begin bus0.req = rq; bus0.we = w; bus0.be = b; bus0.addr = a; bus0.datain = dn; end
            2: begin bus2.req = rq; bus2.we = w; bus2.be = b; bus2.addr = a; bus2.datain = dn; end
            default: begin bus4.req = rq; bus4.we = w; bus4.be = b; bus4.addr = a; bus4.datain = dn; end
        endcase
    endtask

    task automatic wait_idle(input int k, input int tag);
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (busy_of(k) == 1'b0 && qsize(k) == 0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL tag%0d timeout: got busy or pending rdy after 40 cycles, want idle", tag);
        end
    endtask

    // Single access: expected rdy cycle is the accept edge count plus the wait states.
    task automatic access(input int k, input logic w, input logic [3:0] b, input logic [31:0] a,
                          input logic [31:0] dn, input logic [31:0] ed, input logic ee, input int tag);
        int wc;
        wc = (k == 0) ? 0 : (k == 2) ? 2 : 4;
        drive(k, 1'b1, w, b, a, dn);
        @(posedge clk); #1;
        push(k, ed, ee, cyc + wc, tag);
        drive(k, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        wait_idle(k, tag);
    endtask

    initial begin
        int a;
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(2, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst  = 1'b0;
        rst4 = 1'b0;

        @(negedge clk);
        chk(1, "reset_rdy",     {31'b0, bus2.rdy},  32'h0);
        chk(1, "reset_busy",    {31'b0, bus2.busy}, 32'h0);
        chk(1, "reset_err",     {31'b0, bus2.err},  32'h0);
        chk(1, "reset_dataout", bus2.dataout,       32'h0);

        // First read: busy must cover exactly the three cycles up to rdy.
        drive(2, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        @(posedge clk); #1;
        push(2, 32'h0, 1'b0, cyc + 2, 10);
        drive(2, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk(10, "busy_high", {31'b0, bus2.busy}, 32'h1);
        end
        @(negedge clk);
        chk(10, "busy_low", {31'b0, bus2.busy}, 32'h0);
        wait_idle(2, 10);

        access(2, 1'b1, 4'hF, 32'h84, 32'hDEADBEEF, 32'h0,        1'b0, 11);
        access(2, 1'b0, 4'hF, 32'h84, 32'h0,        32'hDEADBEEF, 1'b0, 12);
        access(2, 1'b0, 4'hF, 32'h87, 32'h0,        32'hDEADBEEF, 1'b0, 13);
        access(2, 1'b1, 4'hF, 32'h10, 32'h11223344, 32'hDEADBEEF, 1'b0, 14);
        access(2, 1'b1, 4'h5, 32'h10, 32'hAABBCCDD, 32'hDEADBEEF, 1'b0, 15);
`ifdef MCMEM_BYTE_EN
        access(2, 1'b0, 4'hF, 32'h10, 32'h0,        32'h11BB33DD, 1'b0, 16);
`else
        access(2, 1'b0, 4'hF, 32'h10, 32'h0,        32'hAABBCCDD, 1'b0, 16);
`endif
        access(2, 1'b0, 4'hF, 32'h84,       32'h0,        32'hDEADBEEF, 1'b0, 17);
        access(2, 1'b1, 4'hF, 32'h100,      32'h12345678, 32'h0,        1'b1, 18);
        access(2, 1'b0, 4'hF, 32'h00,       32'h0,        32'h0,        1'b0, 19);
        access(2, 1'b0, 4'hF, 32'h84,       32'h0,        32'hDEADBEEF, 1'b0, 20);
        access(2, 1'b0, 4'hF, 32'h40000004, 32'h0,        32'h0,        1'b1, 21);
        access(2, 1'b1, 4'h0, 32'h84,       32'h0,        32'h0,        1'b0, 22);
`ifdef MCMEM_BYTE_EN
        access(2, 1'b0, 4'hF, 32'h84,       32'h0,        32'hDEADBEEF, 1'b0, 23);
`else
        access(2, 1'b0, 4'hF, 32'h84,       32'h0,        32'h0,        1'b0, 23);
`endif

        // Zero wait states, req held high: accepts every second edge.
        access(0, 1'b1, 4'hF, 32'h8, 32'h55AA1234, 32'h0, 1'b0, 40);
        access(0, 1'b1, 4'hF, 32'hC, 32'h0BADF00D, 32'h0, 1'b0, 41);
        drive(0, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
        @(posedge clk); #1;
        a = cyc;
        push(0, 32'h55AA1234, 1'b0, a,     42);
        push(0, 32'h0BADF00D, 1'b0, a + 2, 43);
        push(0, 32'h55AA1234, 1'b0, a + 4, 44);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 4'hF, 32'hC, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        wait_idle(0, 44);

        // Reset two cycles into a four-wait-state write abandons it silently.
        access(4, 1'b1, 4'hF, 32'h20, 32'h13579BDF, 32'h0, 1'b0, 50);
        drive(4, 1'b1, 1'b1, 4'hF, 32'h20, 32'hCAFEF00D);
        @(posedge clk); #1;
        drive(4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst4 = 1'b1;
        @(posedge clk); #1;
        rst4 = 1'b0;
        repeat (8) @(negedge clk);
        chk(51, "busy_after_abort",    {31'b0, bus4.busy}, 32'h0);
        chk(51, "dataout_after_abort", bus4.dataout,       32'h0);
        access(4, 1'b0, 4'hF, 32'h20, 32'h0, 32'h13579BDF, 1'b0, 52);

        repeat (4) @(negedge clk);
        chk(90, "pending_w0", qsize(0), 32'h0);
        chk(90, "pending_w2", qsize(2), 32'h0);
        chk(90, "pending_w4", qsize(4), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mcmem_wait.md
# mcmem_wait

Parametrised single-port word memory for the multi-cycle CPU with a request/ready handshake, programmable wait states and out-of-range detection. It replaces the zero-latency combinational-read memory so the CPU control FSM can be exercised against slow memory. It sits between the multi-cycle datapath's address/data registers and the control unit, which stalls in its memory-access state until `rdy`.

## Interface
- `DEPTH_LOG2`, 6, log2 of word count; 64 words at the default.
- `WAIT_CYCLES`, 2, wait states inserted between request acceptance and completion; 0 is legal.
- `clk  in  1  clock; all state changes on the rising edge`
- `rst  in  1  synchronous, active-high reset`
- `req  in  1  access request; sampled only in IDLE`
- `we  in  1  1 = write, 0 = read; sampled with req`
- `be  in  4  byte enables; be[0] = bits 7:0; sampled with req`
- `addr  in  32  byte address; word index = addr[DEPTH_LOG2+1:2]; addr[1:0] ignored`
- `datain  in  32  write data; sampled with req`
- `dataout  out  32  registered read data`
- `rdy  out  1  one-cycle completion pulse`
- `busy  out  1  high whenever state is not IDLE`
- `err  out  1  out-of-range flag, valid only while rdy = 1`

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE with req = 1 is acceptance. Acceptance latches addr, we, be and datain.
  - WAIT_CYCLES = 0: go to DONE and perform the access at the same edge.
  - Otherwise: go to WAIT and load the counter with WAIT_CYCLES-1.
- WAIT:
  - counter != 0: decrement.
  - counter == 0: go to DONE and perform the access at that edge, using the latched values.
- DONE lasts exactly one cycle, then returns to IDLE. rdy = 1 only in DONE.
- req is ignored in WAIT and DONE. The next request is accepted in IDLE at the earliest.
- Out of range means any latched addr bit [31:DEPTH_LOG2+2] is nonzero. In that case err = 1 during DONE, no memory write occurs, and dataout is loaded with 0.
- Read in range: dataout ← ram[index]. Otherwise dataout holds its value, including across writes.
- Write in range: the byte lanes selected by be are updated. Unselected lanes are unchanged. be = 0 is a completed no-op write.
- Memory array is initialised to all zeros at time 0 and is not cleared by rst.

## Timing
- Accept edge E0. rdy is high in the cycle after edge E0+WAIT_CYCLES, so latency is WAIT_CYCLES+1 cycles.
- Maximum throughput is one access per WAIT_CYCLES+2 cycles.
- busy rises in the cycle after E0 and falls in the cycle after DONE.
- dataout and err are valid in the rdy cycle. dataout then holds until the next completed in-range read or an out-of-range access.
- Reset values: state IDLE, counter 0, rdy 0, busy 0, err 0, dataout 0.
- rst has priority over everything.
  - rst high at the completing edge: no write occurs and dataout is not updated.
  - rst mid-WAIT: the access is abandoned with no rdy pulse.
- req held high continuously gives a new acceptance in every IDLE cycle. There is no queueing.

## Configuration
- `MCMEM_BYTE_EN` defined: be is honoured per byte lane as described under Operation.
- `MCMEM_BYTE_EN` undefined: be is ignored and every in-range write updates all 32 bits. The port stays present for interface compatibility.

## Test plan
- Default parameters, reset, then read addr 0x00. Required: rdy high exactly 3 cycles after the accept edge, dataout = 0x00000000, err = 0, busy high in the 3 cycles up to and including the rdy cycle.
- Write 0xDEADBEEF to addr 0x84 with be = 4'hF, then read 0x84. Required: dataout = 0xDEADBEEF.
  - Reading 0x87 returns the same word.
- With `MCMEM_BYTE_EN`: write 0x11223344 to 0x10 with be = 4'hF, then 0xAABBCCDD with be = 4'b0101, then read 0x10. Required: 0x11BB33DD.
  - Without the macro the same sequence returns 0xAABBCCDD.
- Write 0x12345678 to addr 0x100 (out of range at DEPTH_LOG2 = 6). Required: rdy with err = 1, dataout = 0, and a read of 0x00 unchanged.
- WAIT_CYCLES = 0: issue back-to-back reads with req held high. Required: rdy in the cycle after each accept, and accepts every 2 cycles.
- WAIT_CYCLES = 4: start a write of 0xCAFEF00D to 0x20, assert rst for one cycle two cycles after accept, then read 0x20. Required: no rdy pulse for the aborted write, and the read returns the old value.
